// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, FSM state encoding, data width.
// Also imported by the ALU control decoder so both agree on the codes.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MULT = 4'b1000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    function automatic logic is_mult(input logic [3:0] ctrl);
        return ctrl == ALU_MULT;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the datapath (master) and seq_alu (slave).
// Ports: start_i/ctrl_i/src1_i/src2_i in; result_o/zero_o/busy_o/done_o out.
interface seq_alu_if #(
    parameter int DATA_W = 32
);

    logic              start_i;
    logic [3:0]        ctrl_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic [DATA_W-1:0] result_o;
    logic              zero_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output start_i, ctrl_i, src1_i, src2_i,
        input  result_o, zero_o, busy_o, done_o
    );

    modport slave (
        input  start_i, ctrl_i, src1_i, src2_i,
        output result_o, zero_o, busy_o, done_o
    );

endinterface

// File: rtl/shift_add_mul.sv
// Radix-2 shift-add multiplier datapath: one partial product per step.
// Ports: load/step controls, operands, product (next accumulator), last.
module shift_add_mul #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] mcand_in,
    input  logic [DATA_W-1:0] mplier_in,
    output logic [DATA_W-1:0] product,
    output logic              last
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] addend;
    logic [DATA_W-1:0] acc_next;

    // Only the low DATA_W product bits are kept, so the multiplicand
    // may shift its upper bits out without changing the result.
    assign addend   = mplier[0] ? mcand : '0;
    assign acc_next = acc + addend;

    // Exposing the post-step value lets the owner capture the full
    // product on the same edge as the final iteration.
    assign product = acc_next;
    assign last    = step && (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= mcand_in;
            mplier <= mplier_in;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, DATA_W-cycle MULT.
// Ports: clk_i, rst_i (sync, active-low), bus (seq_alu_if slave).
module seq_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    seq_alu_if.slave  bus
);

    state_t            state;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] alu_res;
    logic              mul_load;
    logic              mul_step;
    logic [DATA_W-1:0] mul_product;
    logic              mul_last;

    always_comb begin
        alu_res = '0;
        case (bus.ctrl_i)
            ALU_AND: alu_res = bus.src1_i & bus.src2_i;
            ALU_OR:  alu_res = bus.src1_i | bus.src2_i;
            ALU_ADD: alu_res = bus.src1_i + bus.src2_i;
            ALU_SUB: alu_res = bus.src1_i - bus.src2_i;
            ALU_SLT: begin
                if ($signed(bus.src1_i) < $signed(bus.src2_i))
                    alu_res = DATA_W'(1);
            end
            default: alu_res = '0;
        endcase
    end

    assign mul_load = (state == IDLE) && bus.start_i && is_mult(bus.ctrl_i);
    assign mul_step = (state == MUL);

    shift_add_mul #(
        .DATA_W(DATA_W)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load      (mul_load),
        .step      (mul_step),
        .mcand_in  (bus.src1_i),
        .mplier_in (bus.src2_i),
        .product   (mul_product),
        .last      (mul_last)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            result <= '0;
            zero   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        if (is_mult(bus.ctrl_i)) begin
                            busy  <= 1'b1;
                            state <= MUL;
                        end else begin
                            result <= alu_res;
                            zero   <= (alu_res == '0);
                            done   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        result <= mul_product;
                        zero   <= (mul_product == '0);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result_o = result;
    assign bus.zero_o   = zero;
    assign bus.busy_o   = busy;
    assign bus.done_o   = done;

endmodule
